// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - run-time loadable instruction memory with registered fetch port
// Optional PARITY_CHECK_EN: stores an even-parity bit per word and flags mismatches on fetch via par_err.
module instr_mem_loadable #(
   parameter int W = 9,
   parameter int D = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld_start,
   input  logic         ld_valid,
   input  logic [W-1:0] ld_data,
   input  logic         ld_done,
   output logic [D:0]   ld_count,
   input  logic         rd_en,
   input  logic [D-1:0] prog_ctr,
   input  logic         stall,
   output logic [W-1:0] mach_code,
   output logic         mach_valid,
   output logic         ready,
   output logic         ld_overflow
`ifdef PARITY_CHECK_EN
   ,
   output logic         par_err
`endif
);

`ifdef PARITY_CHECK_EN
   localparam int MW = W + 1;
`else
   localparam int MW = W;
`endif
   localparam logic [D:0] DEPTH = {1'b1, {D{1'b0}}};
   localparam logic [D:0] ONE   = (D+1)'(1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   state_t state;

   logic [MW-1:0] mem [0:(1<<D)-1];
   logic          wr_en;
   logic [D-1:0]  wr_addr;
   logic [MW-1:0] wr_word;
   logic [MW-1:0] rd_word;

   // A restart in LOAD writes its companion word to address 0, not the stale count.
   assign wr_en   = (state == LOAD) && ld_valid && (ld_start || (ld_count != DEPTH));
   assign wr_addr = ld_start ? '0 : ld_count[D-1:0];
`ifdef PARITY_CHECK_EN
   assign wr_word = {^ld_data, ld_data};
`else
   assign wr_word = ld_data;
`endif
   assign rd_word = mem[prog_ctr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ready       <= 1'b0;
         ld_count    <= '0;
         ld_overflow <= 1'b0;
         mach_code   <= '0;
         mach_valid  <= 1'b0;
`ifdef PARITY_CHECK_EN
         par_err     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (ld_start) begin
                  state       <= LOAD;
                  ld_count    <= '0;
                  ld_overflow <= 1'b0;
               end else if (ld_done) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            LOAD: begin
               if (ld_start) begin
                  ld_count    <= ld_valid ? ONE : '0;
                  ld_overflow <= 1'b0;
               end else begin
                  if (ld_valid) begin
                     if (ld_count != DEPTH) ld_count <= ld_count + ONE;
                     else                   ld_overflow <= 1'b1;
                  end
                  if (ld_done) begin
                     state <= RUN;
                     ready <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (ld_start) begin
                  state       <= LOAD;
                  ready       <= 1'b0;
                  ld_count    <= '0;
                  ld_overflow <= 1'b0;
                  mach_valid  <= 1'b0;
`ifdef PARITY_CHECK_EN
                  par_err     <= 1'b0;
`endif
               end else if (!stall) begin
                  // Under stall everything holds and the request is simply dropped.
                  if (rd_en) begin
                     mach_code  <= rd_word[W-1:0];
                     mach_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
                     par_err    <= ^rd_word;
`endif
                  end else begin
                     mach_valid <= 1'b0;
`ifdef PARITY_CHECK_EN
                     par_err    <= 1'b0;
`endif
                  end
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised instruction memory; successor to the fixed 9-bit combinational instruction ROM.
- Generalised in word width and depth.
- Loaded at run time through a sequential load port instead of file initialisation.
- Synchronous, registered read with valid/stall handshake toward the fetch stage, between program counter and decoder.

Parameters:
W, 9, instruction word width in bits
D, 12, address width; memory holds 2**D words

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ld_start  input  1  pulse: begin load session, load address cleared to 0
ld_valid  input  1  load word present on ld_data this cycle
ld_data  input  W  word to write
ld_done  input  1  pulse: end load session, enter RUN
ld_count  output  D+1  number of words written in current/last session
rd_en  input  1  fetch request, address on prog_ctr
prog_ctr  input  D  fetch address
stall  input  1  downstream not ready; hold output
mach_code  output  W  fetched instruction
mach_valid  output  1  mach_code holds a valid fetched word
ready  output  1  block in RUN and accepting fetches
ld_overflow  output  1  sticky: write attempted with ld_count == 2**D

Behaviour:
- States: IDLE, LOAD, RUN. Reset (async, rst_n=0) enters IDLE.
- Reset values: mach_code=0, mach_valid=0, ready=0, ld_count=0, ld_overflow=0. Memory contents are not reset.
- IDLE:
  - ld_start -> LOAD: ld_count=0, ld_overflow=0.
  - ld_done with no ld_start -> RUN, contents unchanged.
- LOAD:
  - ld_valid=1 and ld_count<2**D: write ld_data at address ld_count[D-1:0], then ld_count+1.
  - ld_valid=1 at ld_count==2**D: no write; set ld_overflow; ld_count saturates.
  - ld_done -> RUN next cycle. A word presented with ld_valid in the same cycle as ld_done is still written.
  - ld_start in LOAD restarts the session: ld_count=0, overflow cleared; ld_valid in that cycle writes address 0 and ld_count becomes 1.
  - rd_en ignored; ready=0.
- RUN:
  - ready=1.
  - When rd_en=1 and stall=0: mach_code <= mem[prog_ctr] and mach_valid <= 1. This is a fixed 1-cycle latency.
  - When rd_en=0 and stall=0: mach_valid <= 0 and mach_code holds its last value.
  - stall=1: mach_code and mach_valid hold regardless of rd_en; the request is dropped and the PC owner re-presents it.
  - ld_start -> LOAD, with mach_valid cleared in the same edge.
- Simultaneous ld_start and ld_done: ld_start wins.
- Reset mid-load: return to IDLE and zero the counters. Partially written words remain in memory.
- Addresses wrap naturally at 2**D. No out-of-range condition exists on prog_ctr.
- Memory must infer as synchronous-read block RAM: one write port (load), one read port (fetch).

Optional Feature:
Macro PARITY_CHECK_EN.
- Defined:
  - Memory is W+1 bits wide; an even-parity bit over ld_data is stored on each write.
  - On each fetch the parity is recomputed.
  - Adds output port par_err (1 bit, reset 0). It is asserted alongside mach_valid when a mismatch is found, and holds with mach_code under stall.
- Undefined: memory is W bits wide and par_err is absent. Behaviour is otherwise identical.

Test Plan:
- Reset then load: ld_start; write words 9'b001111110, 9'b001100110, 9'b001111010 at addresses 0..2; ld_done -> ld_count=3, ready=1 the cycle after ld_done.
- Fetch latency: RUN, rd_en=1, prog_ctr=1 at cycle n -> mach_code=9'b001100110, mach_valid=1 at cycle n+1. With rd_en=0 at n+1 -> mach_valid=0 at n+2.
- Stall hold: fetch addr 2, then stall=1 for 3 cycles with prog_ctr=0 -> mach_code stays 9'b001111010 with mach_valid=1. Release stall -> addr 0 word appears the next cycle.
- Overflow: D=2; load 5 words -> ld_count=4, ld_overflow=1, address 0 still holds word 0.
- Reset mid-load: after 2 writes assert rst_n=0 -> all outputs return to reset values asynchronously and state is IDLE. ld_done then gives RUN, and addresses 0..1 read back the words written before reset.
- PARITY_CHECK_EN: force a stored bit flip at addr 0 through the bench back-door -> fetch addr 0 gives par_err=1 with mach_valid=1. A clean address gives par_err=0.
